// File: rtl/f_stage_ctrl.sv
// f_stage_ctrl: sequences one f-stage of an SC polar decoder.
// Reads upper/lower alpha half-block word pairs, runs P parallel f lanes
// (sign(a)*sign(b)*min(|a|,|b|)), and writes packed results back in order.
// Read-to-write latency is 2 cycles.
// Optional build macro F_STAGE_CTRL_PERF_EN adds the perf_cycles_o and
// perf_stages_o counters.
module f_stage_ctrl #(
  parameter int unsigned BITWIDTH = 7,
  parameter int unsigned P        = 4,
  parameter int unsigned LOG2N    = 10,
  parameter int unsigned AW       = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [$clog2(LOG2N):0]   stage_log2_i,
  input  logic [AW-1:0]            rd_base_i,
  input  logic [AW-1:0]            wr_base_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic                     rd_en_o,
  output logic [AW-1:0]            rd_addr_a_o,
  output logic [AW-1:0]            rd_addr_b_o,
  input  logic [P*BITWIDTH-1:0]    rd_data_a_i,
  input  logic [P*BITWIDTH-1:0]    rd_data_b_i,
  output logic                     wr_en_o,
  output logic [AW-1:0]            wr_addr_o,
  output logic [P*BITWIDTH-1:0]    wr_data_o
`ifdef F_STAGE_CTRL_PERF_EN
  ,
  output logic [31:0]              perf_cycles_o,
  output logic [15:0]              perf_stages_o
`endif
);

  localparam int unsigned LOG2P = $clog2(P);
  // Word counters only need to hold W <= 2^(LOG2N-1).
  localparam int unsigned CW    = LOG2N;
  localparam int unsigned DW    = P * BITWIDTH;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e          state_q;
  logic [AW-1:0]   rd_base_q;
  logic [AW-1:0]   wr_base_q;
  logic [CW-1:0]   w_q;
  logic [CW-1:0]   j_q;
  logic [CW-1:0]   wr_cnt_q;
  logic            rd_vld_q;
  logic            rd_last_q;

  logic            k_legal;
  logic [CW-1:0]   w_calc;
  logic [DW-1:0]   f_res;

  // f(a,b); inputs never hit the most negative code, so |a| fits in BITWIDTH bits.
  function automatic logic [BITWIDTH-1:0] f_fn(input logic signed [BITWIDTH-1:0] a,
                                               input logic signed [BITWIDTH-1:0] b);
    logic [BITWIDTH-1:0] ma;
    logic [BITWIDTH-1:0] mb;
    logic [BITWIDTH-1:0] mn;
    ma = a[BITWIDTH-1] ? BITWIDTH'(-a) : BITWIDTH'(a);
    mb = b[BITWIDTH-1] ? BITWIDTH'(-b) : BITWIDTH'(b);
    mn = (ma < mb) ? ma : mb;
    return (a[BITWIDTH-1] ^ b[BITWIDTH-1]) ? BITWIDTH'(-mn) : mn;
  endfunction

  // Stage-size decode: legality of k and word count W = 2^(k-log2 P).
  always_comb begin
    k_legal = (32'(stage_log2_i) >= LOG2P) && (32'(stage_log2_i) <= LOG2N - 1);
    w_calc  = '0;
    if (k_legal) begin
      w_calc = CW'(1) << (32'(stage_log2_i) - LOG2P);
    end
  end

  // P parallel f lanes on the word pair returned by the RAM.
  always_comb begin
    f_res = '0;
    for (int i = 0; i < P; i++) begin
      f_res[i*BITWIDTH +: BITWIDTH] = f_fn(rd_data_a_i[i*BITWIDTH +: BITWIDTH],
                                           rd_data_b_i[i*BITWIDTH +: BITWIDTH]);
    end
  end

  // Control FSM, read issue and write-back pipeline with registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      rd_base_q   <= '0;
      wr_base_q   <= '0;
      w_q         <= '0;
      j_q         <= '0;
      wr_cnt_q    <= '0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      rd_en_o     <= 1'b0;
      rd_addr_a_o <= '0;
      rd_addr_b_o <= '0;
      wr_en_o     <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
    end else begin
      err_o  <= 1'b0;
      done_o <= 1'b0;

      // Data for a read issued last cycle is on the bus now; register its result.
      rd_vld_q  <= rd_en_o;
      rd_last_q <= rd_en_o && (j_q == w_q);
      wr_en_o   <= rd_vld_q;
      if (rd_vld_q) begin
        wr_data_o <= f_res;
        wr_addr_o <= wr_base_q + AW'(wr_cnt_q);
        wr_cnt_q  <= wr_cnt_q + CW'(1);
        done_o    <= rd_last_q;
      end

      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            if (k_legal) begin
              state_q     <= StRun;
              busy_o      <= 1'b1;
              rd_en_o     <= 1'b1;
              rd_base_q   <= rd_base_i;
              wr_base_q   <= wr_base_i;
              w_q         <= w_calc;
              rd_addr_a_o <= rd_base_i;
              rd_addr_b_o <= rd_base_i + AW'(w_calc);
              j_q         <= CW'(1);
              wr_cnt_q    <= '0;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        StRun: begin
          // j_q is the index of the next read; reaching W means all are issued.
          if (j_q == w_q) begin
            state_q <= StDrain;
            rd_en_o <= 1'b0;
          end else begin
            rd_addr_a_o <= rd_base_q + AW'(j_q);
            rd_addr_b_o <= rd_base_q + AW'(w_q) + AW'(j_q);
            j_q         <= j_q + CW'(1);
          end
        end
        StDrain: begin
          if (done_o) begin
            state_q <= StIdle;
            busy_o  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_o  <= 1'b0;
          rd_en_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef F_STAGE_CTRL_PERF_EN
  // Busy-cycle counter (saturating) and completed-stage counter (wrapping).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_cycles_o <= '0;
      perf_stages_o <= '0;
    end else begin
      if (busy_o && (perf_cycles_o != '1)) begin
        perf_cycles_o <= perf_cycles_o + 32'd1;
      end
      if (done_o) begin
        perf_stages_o <= perf_stages_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_f_stage_ctrl.sv
// Directed self-checking bench for f_stage_ctrl (P=4, BITWIDTH=7, LOG2N=10, AW=8).
module tb_f_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  k;
  logic [7:0]  rd_base;
  logic [7:0]  wr_base;
  logic        busy, done, err, rd_en, wr_en;
  logic [7:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic [27:0] rd_data_a, rd_data_b, wr_data;
`ifdef F_STAGE_CTRL_PERF_EN
  logic [31:0] perf_cycles;
  logic [15:0] perf_stages;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Monitor counters and write log, only ever written by the monitor.
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          busy_cnt = 0;
  logic [7:0]  wlog_addr [64];
  logic [27:0] wlog_data [64];
  logic [27:0] mem [256];

  always #5 clk = ~clk;

  f_stage_ctrl #(
    .BITWIDTH(7),
    .P(4),
    .LOG2N(10),
    .AW(8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .stage_log2_i (k),
    .rd_base_i    (rd_base),
    .wr_base_i    (wr_base),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .rd_en_o      (rd_en),
    .rd_addr_a_o  (rd_addr_a),
    .rd_addr_b_o  (rd_addr_b),
    .rd_data_a_i  (rd_data_a),
    .rd_data_b_i  (rd_data_b),
    .wr_en_o      (wr_en),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data)
`ifdef F_STAGE_CTRL_PERF_EN
    ,
    .perf_cycles_o(perf_cycles),
    .perf_stages_o(perf_stages)
`endif
  );

  // RAM model with 1-cycle read latency, plus activity monitor.
  always @(posedge clk) begin
    if (rd_en === 1'b1) begin
      rd_data_a <= mem[rd_addr_a];
      rd_data_b <= mem[rd_addr_b];
      rd_cnt    <= rd_cnt + 1;
    end
    if (wr_en === 1'b1) begin
      wlog_addr[wr_cnt % 64] <= wr_addr;
      wlog_data[wr_cnt % 64] <= wr_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (err === 1'b1)  err_cnt  <= err_cnt + 1;
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
  end

  function automatic logic [27:0] pack4(input int l0, input int l1, input int l2, input int l3);
    logic [27:0] r;
    r[6:0]   = 7'(l0);
    r[13:7]  = 7'(l1);
    r[20:14] = 7'(l2);
    r[27:21] = 7'(l3);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [27:0] exp_multi [4];
  int rd0, wr0, done0, err0, busy0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = pack4(5, -3, 7, -1);
    mem[8'h11] = pack4(-2, -6, 4, -8);
    for (int j = 0; j < 4; j++) begin
      mem[8'h20 + j] = pack4(j + 1, -(j + 2), 10, -20);
      mem[8'h24 + j] = pack4(-3, 5, -(j + 8), -15);
    end
    exp_multi[0] = pack4(-1, -2, -8, 15);
    exp_multi[1] = pack4(-2, -3, -9, 15);
    exp_multi[2] = pack4(-3, -4, -10, 15);
    exp_multi[3] = pack4(-3, -5, -10, 15);

    // Reset with start held high.
    rst = 1'b1; start = 1'b1; k = 5'd4; rd_base = 8'h20; wr_base = 8'h80;
    tick();
    check("reset_ctl_0", {27'd0, busy, done, err, rd_en, wr_en}, 32'd0);
    tick();
    check("reset_ctl_1", {27'd0, busy, done, err, rd_en, wr_en}, 32'd0);
    check("reset_addr", {8'd0, rd_addr_a, rd_addr_b, wr_addr}, 32'd0);
    check("reset_no_read", rd_cnt, 0);
    rst = 1'b0; start = 1'b0;
    tick();

    // Single word: k=2.
    busy0 = busy_cnt; wr0 = wr_cnt;
    start = 1'b1; k = 5'd2; rd_base = 8'h10; wr_base = 8'h40;
    tick();
    start = 1'b0;
    check("sw_read", {15'd0, busy, rd_en, rd_addr_a, rd_addr_b}, {15'd0, 2'b11, 8'h10, 8'h11});
    tick();
    check("sw_gap", {29'd0, busy, rd_en, wr_en}, 32'b100);
    tick();
    check("sw_write_ctl", {29'd0, busy, wr_en, done}, 32'b111);
    check("sw_write_addr", wr_addr, 8'h40);
    check("sw_write_data", wr_data, pack4(-2, 3, 4, 1));
    tick();
    check("sw_end", {30'd0, busy, done}, 32'd0);
    check("sw_busy_len", busy_cnt - busy0, 3);
    check("sw_wr_count", wr_cnt - wr0, 1);

    // Multi word: k=4, W=4.
    busy0 = busy_cnt; wr0 = wr_cnt; done0 = done_cnt;
    start = 1'b1; k = 5'd4; rd_base = 8'h20; wr_base = 8'h80;
    tick();
    start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      check("mw_read", {15'd0, rd_en, rd_addr_a, rd_addr_b}, {15'd0, 1'b1, 8'(8'h20 + j),
            8'(8'h24 + j)});
      check("mw_no_done", {31'd0, done}, 32'd0);
      tick();
    end
    check("mw_drain", {30'd0, busy, rd_en}, 32'b10);
    tick();
    check("mw_done", {29'd0, busy, wr_en, done}, 32'b111);
    check("mw_done_addr", wr_addr, 8'h83);
    tick();
    check("mw_end", {30'd0, busy, wr_en}, 32'd0);
    check("mw_busy_len", busy_cnt - busy0, 6);
    check("mw_wr_count", wr_cnt - wr0, 4);
    check("mw_done_count", done_cnt - done0, 1);
    for (int j = 0; j < 4; j++) begin
      check("mw_log_addr", wlog_addr[wr0 + j], 8'(8'h80 + j));
      check("mw_log_data", wlog_data[wr0 + j], exp_multi[j]);
    end

    // Illegal k: 1 then 10.
    rd0 = rd_cnt; err0 = err_cnt; busy0 = busy_cnt;
    start = 1'b1; k = 5'd1;
    tick();
    start = 1'b0;
    check("ill_k1_err", {30'd0, err, busy}, 32'b10);
    tick();
    check("ill_k1_pulse", {31'd0, err}, 32'd0);
    start = 1'b1; k = 5'd10;
    tick();
    start = 1'b0;
    check("ill_k10_err", {30'd0, err, busy}, 32'b10);
    tick();
    tick();
    check("ill_err_count", err_cnt - err0, 2);
    check("ill_no_read", rd_cnt - rd0, 0);
    check("ill_no_busy", busy_cnt - busy0, 0);

    // Overlap: start held through a k=3 stage (W=2, busy 4 cycles).
    done0 = done_cnt;
    start = 1'b1; k = 5'd3; rd_base = 8'h30; wr_base = 8'h50;
    tick();
    check("ov_first_read", {15'd0, rd_en, rd_addr_a, rd_addr_b}, {15'd0, 1'b1, 8'h30, 8'h32});
    tick();
    tick();
    tick();
    check("ov_done", {30'd0, busy, done}, 32'b11);
    tick();
    check("ov_not_in_done", {30'd0, busy, rd_en}, 32'd0);
    tick();
    start = 1'b0;
    check("ov_restart", {15'd0, busy, rd_en, rd_addr_a}, {23'd0, 1'b1, 1'b1, 8'h30} & 32'h3FF);
    tick();
    tick();
    tick();
    check("ov_done2", {31'd0, done}, 32'd1);
    tick();
    check("ov_idle", {31'd0, busy}, 32'd0);
    check("ov_done_count", done_cnt - done0, 2);

    // Abort: reset during the 2nd read of a k=4 stage.
    wr0 = wr_cnt; done0 = done_cnt;
    start = 1'b1; k = 5'd4; rd_base = 8'h20; wr_base = 8'h80;
    tick();
    start = 1'b0;
    tick();
    check("ab_second_read", {23'd0, rd_en, rd_addr_a}, {23'd0, 1'b1, 8'h21});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ab_reset_ctl", {27'd0, busy, done, err, rd_en, wr_en}, 32'd0);
    for (int i = 0; i < 6; i++) tick();
    check("ab_no_write", wr_cnt - wr0, 0);
    check("ab_no_done", done_cnt - done0, 0);

    // Address wrap: rd_base=0xFE, k=3.
    wr0 = wr_cnt;
    start = 1'b1; k = 5'd3; rd_base = 8'hFE; wr_base = 8'h10;
    tick();
    start = 1'b0;
    check("wr_read0", {15'd0, rd_en, rd_addr_a, rd_addr_b}, {15'd0, 1'b1, 8'hFE, 8'h00});
    tick();
    check("wr_read1", {15'd0, rd_en, rd_addr_a, rd_addr_b}, {15'd0, 1'b1, 8'hFF, 8'h01});
    tick();
    tick();
    check("wr_done", {30'd0, done, wr_en}, 32'b11);
    check("wr_done_addr", wr_addr, 8'h11);
    tick();
    check("wr_wr_count", wr_cnt - wr0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/f_stage_ctrl.md
Name: f_stage_ctrl

Overview:
- Sequences one f-stage of the SC polar decoder over a bank of P parallel f-function lanes.
- Each lane computes sign(a)·sign(b)·min(|a|,|b|).
- On a start request, walks the upper and lower alpha half-blocks in LLR memory, feeds word pairs to the lanes and writes the packed results back.
- Sits between the decoder top-level scheduler (start/done) and the LLR RAM (two read ports, one write port).

Parameters:
- BITWIDTH, 7, LLR width (signed two's complement).
- P, 4, number of parallel f lanes = LLRs per memory word; power of 2, ≥1.
- LOG2N, 10, log2 of max code length N.
- AW, 8, memory word-address width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  stage request; accepted only in IDLE
- stage_log2_i  in  $clog2(LOG2N)+1  k: stage produces M=2^k LLRs
- rd_base_i  in  AW  word address of alpha block (upper half first)
- wr_base_i  in  AW  word address for result block
- busy_o  out  1  stage in progress
- done_o  out  1  one-cycle pulse, stage complete
- err_o  out  1  one-cycle pulse, illegal k rejected
- rd_en_o  out  1  read strobe, both ports
- rd_addr_a_o  out  AW  upper-half word address
- rd_addr_b_o  out  AW  lower-half word address
- rd_data_a_i  in  P*BITWIDTH  port A data, 1-cycle latency
- rd_data_b_i  in  P*BITWIDTH  port B data, 1-cycle latency
- wr_en_o  out  1  write strobe
- wr_addr_o  out  AW  write word address
- wr_data_o  out  P*BITWIDTH  packed f results

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, pipeline valids cleared. Reset mid-stage aborts it: in-flight reads and writes are dropped, no done_o.
- Lane packing: lane i occupies bits [i*BITWIDTH +: BITWIDTH].
- Lane i result = f(a_i, b_i), using the team's f-function block unchanged. Inputs are guaranteed in [-(2^(BITWIDTH-1)-1), +max] by upstream saturation.
- Legal k: log2(P) ≤ k ≤ LOG2N-1. Word count W = 2^(k-log2 P).
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - start_i=1 with legal k: latch bases and W, clear j, go to RUN, busy_o=1 next cycle.
  - start_i=1 with illegal k: err_o=1 next cycle for one cycle, stay IDLE, no memory access.
- RUN, each cycle:
  - rd_en_o=1, rd_addr_a_o = rd_base+j, rd_addr_b_o = rd_base+W+j; j increments.
  - After issuing j=W-1, go to DRAIN.
- Pipeline:
  - Read issued in cycle c; data arrives c+1; lanes compute combinationally; result registered.
  - In cycle c+2: wr_en_o=1, wr_addr_o = wr_base+j, wr_data_o = registered result.
  - Read-to-write latency is 2 cycles; writes are strictly in order, one per cycle, no gaps.
- DRAIN: no reads. The cycle carrying the final write asserts done_o=1, then the FSM returns to IDLE.
- Timing: busy_o is high for W+2 cycles, from the first read cycle through the final write/done cycle inclusive.
- start_i while busy, including the done cycle, is ignored. The earliest next accept is the cycle after done_o.
- Address arithmetic wraps modulo 2^AW; there is no overlap check between read and write regions.
- Outputs when idle:
  - rd_addr/wr_addr hold their last value.
  - wr_data_o holds its last value.
  - rd_en_o and wr_en_o are 0.

Optional Feature:
- Macro: F_STAGE_CTRL_PERF_EN.
- Defined:
  - Adds output perf_cycles_o (32 bits): count of cycles with busy_o=1 since reset. Saturates at 2^32-1 and is cleared only by rst_i.
  - Adds output perf_stages_o (16 bits): count of done_o pulses, wraps.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan (P=4, BITWIDTH=7, LOG2N=10, AW=8):
- Reset: hold rst_i 2 cycles with start_i=1 -> busy/done/err/rd_en/wr_en all 0, no access.
- Single word:
  - Stimulus: k=2, rd_base=0x10, wr_base=0x40; port A word lanes {5,-3,7,-1}, port B {-2,-6,4,-8}.
  - Response: one read at A=0x10, B=0x11, then wr_addr 0x40 with lanes {-2,3,4,1} two cycles later, done_o on that cycle; busy_o 3 cycles.
- Multi word: k=4, rd_base=0x20, wr_base=0x80 -> reads A 0x20..0x23 paired with B 0x24..0x27 on 4 consecutive cycles; writes 0x80..0x83 in order; busy 6 cycles; done with the 0x83 write.
- Illegal k: k=1, then k=10 -> err_o pulse each time, busy_o stays 0, no rd_en_o.
- Overlap: start_i held high through a k=3 stage -> the second stage begins exactly one cycle after done_o; a start during done is not accepted.
- Abort and wrap: rst_i at the 2nd read of a k=4 stage -> no further wr_en_o or done_o. Then rd_base=0xFE, k=3 -> A reads 0xFE,0xFF, B reads 0x00,0x01.
